// File: rtl/cache_bus_responder_if.sv
// Bus operation handshake between the L1 cache (master) and the bus responder (slave).
interface cache_bus_responder_if;
  logic        bus_req;
  logic [1:0]  bus_op;
  logic [31:0] bus_addr;
  logic        bus_ready;
  logic        bus_busy;
  logic        rsp_valid;
  logic [1:0]  snoop_result;
  logic        c_shared;

  modport master (
    output bus_req, bus_op, bus_addr,
    input  bus_ready, bus_busy, rsp_valid, snoop_result, c_shared
  );

  modport slave (
    input  bus_req, bus_op, bus_addr,
    output bus_ready, bus_busy, rsp_valid, snoop_result, c_shared
  );
endinterface

// File: rtl/cache_bus_responder.sv
// Snoop responder modelling one peer cache's I/S/M line table plus flush/memory latency.
// Optional protocol checking is enabled by defining BUS_RSP_PROTO_CHK_EN.
module cache_bus_responder #(
  parameter int INDEX_BITS   = 4,
  parameter int MEM_LAT      = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  cache_bus_responder_if.slave    bus,
  input  logic                    snp_wr,
  input  logic [31:0]             snp_addr,
  input  logic [1:0]              snp_state,
  output logic [15:0]             hit_cntr,
  output logic [15:0]             hitm_cntr,
  output logic                    proto_err
);
  localparam int DEPTH   = 1 << INDEX_BITS;
  localparam int TAG_W   = 26 - INDEX_BITS;
  localparam int MAX_LAT = (MEM_LAT > FLUSH_CYCLES) ? MEM_LAT : FLUSH_CYCLES;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [1:0] OP_RD = 2'd0, OP_RDX = 2'd1, OP_UPGR = 2'd2, OP_FLUSH = 2'd3;
  localparam logic [1:0] ST_I = 2'd0, ST_S = 2'd1, ST_M = 2'd2;
  localparam logic [1:0] RES_NOHIT = 2'd0, RES_HIT = 2'd1, RES_HITM = 2'd2;

  typedef enum logic [2:0] {IDLE, SNOOP, PFLUSH, MEM, RESP} state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [25:0]        line_q, line_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         res_q, res_d;
  logic               shared_q, shared_d;
  logic               busy_q, busy_d;
  logic [15:0]        hit_q, hit_d;
  logic [15:0]        hitm_q, hitm_d;
  logic [TAG_W-1:0]   tag_tbl_q [DEPTH];
  logic [TAG_W-1:0]   tag_tbl_d [DEPTH];
  logic [1:0]         st_tbl_q  [DEPTH];
  logic [1:0]         st_tbl_d  [DEPTH];
`ifdef BUS_RSP_PROTO_CHK_EN
  logic               proto_q, proto_d;
`endif

  logic [INDEX_BITS-1:0] lk_idx, snp_idx;
  logic [TAG_W-1:0]      lk_tag, snp_tag;
  logic [1:0]            lk_st;
  logic                  lk_match;
  logic                  unused_offsets;

  assign lk_idx   = line_q[INDEX_BITS-1:0];
  assign lk_tag   = line_q[25:INDEX_BITS];
  assign snp_idx  = snp_addr[6 +: INDEX_BITS];
  assign snp_tag  = snp_addr[31:6+INDEX_BITS];
  assign lk_st    = st_tbl_q[lk_idx];
  assign lk_match = ((lk_st == ST_S) || (lk_st == ST_M)) && (tag_tbl_q[lk_idx] == lk_tag);
  assign unused_offsets = ^{bus.bus_addr[5:0], snp_addr[5:0]};

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    line_d    = line_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    shared_d  = shared_q;
    hit_d     = hit_q;
    hitm_d    = hitm_q;
    tag_tbl_d = tag_tbl_q;
    st_tbl_d  = st_tbl_q;
`ifdef BUS_RSP_PROTO_CHK_EN
    proto_d   = proto_q;
`endif
    case (state_q)
      IDLE: begin
        // Preload lands before an accepted op is snooped, so the op sees it.
        if (snp_wr) begin
          tag_tbl_d[snp_idx] = snp_tag;
          st_tbl_d[snp_idx]  = (snp_state == 2'd3) ? ST_I : snp_state;
`ifdef BUS_RSP_PROTO_CHK_EN
          if (snp_state == 2'd3) proto_d = 1'b1;
`endif
        end
        if (bus.bus_req) begin
          op_d    = bus.bus_op;
          line_d  = bus.bus_addr[31:6];
          state_d = SNOOP;
        end
      end
      SNOOP: begin
        res_d    = RES_NOHIT;
        shared_d = 1'b0;
        if (op_q != OP_FLUSH && lk_match) begin
          shared_d = 1'b1;
          res_d    = (lk_st == ST_M) ? RES_HITM : RES_HIT;
          if (op_q == OP_RD && lk_st == ST_M) st_tbl_d[lk_idx] = ST_S;
          else if (op_q == OP_RDX || op_q == OP_UPGR) st_tbl_d[lk_idx] = ST_I;
`ifdef BUS_RSP_PROTO_CHK_EN
          if (op_q == OP_UPGR && lk_st == ST_M) proto_d = 1'b1;
`endif
        end
        if (res_d == RES_HITM) begin
          state_d = PFLUSH;
          cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
        end else if (op_q == OP_UPGR) begin
          state_d = RESP;
        end else begin
          state_d = MEM;
          cnt_d   = CNT_W'(MEM_LAT - 1);
        end
      end
      PFLUSH, MEM: begin
        if (cnt_q == '0) state_d = RESP;
        else cnt_d = cnt_q - 1'b1;
      end
      RESP: begin
        if (res_q == RES_HIT)  hit_d  = hit_q + 16'd1;
        if (res_q == RES_HITM) hitm_d = hitm_q + 16'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= OP_RD;
      line_q   <= '0;
      cnt_q    <= '0;
      res_q    <= RES_NOHIT;
      shared_q <= 1'b0;
      busy_q   <= 1'b0;
      hit_q    <= '0;
      hitm_q   <= '0;
      for (int i = 0; i < DEPTH; i++) st_tbl_q[i] <= ST_I;
`ifdef BUS_RSP_PROTO_CHK_EN
      proto_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      line_q   <= line_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      shared_q <= shared_d;
      busy_q   <= busy_d;
      hit_q    <= hit_d;
      hitm_q   <= hitm_d;
      st_tbl_q <= st_tbl_d;
`ifdef BUS_RSP_PROTO_CHK_EN
      proto_q  <= proto_d;
`endif
    end
  end

  // Tags are meaningless while the state is I, so they need no reset.
  always_ff @(posedge clk) begin
    tag_tbl_q <= tag_tbl_d;
  end

  assign bus.bus_ready    = (state_q == IDLE);
  assign bus.bus_busy     = busy_q;
  assign bus.rsp_valid    = (state_q == RESP);
  assign bus.snoop_result = res_q;
  assign bus.c_shared     = shared_q;
  assign hit_cntr         = hit_q;
  assign hitm_cntr        = hitm_q;
`ifdef BUS_RSP_PROTO_CHK_EN
  assign proto_err        = proto_q;
`else
  assign proto_err        = 1'b0;
`endif
endmodule

// File: doc/cache_bus_responder.md
# cache_bus_responder

Bus-side responder paired with the L1 cache model: it accepts the cache's outgoing bus operations (BusRd, BusRdX, BusUpgr, Flush) and answers with a snoop result and shared indication after modelled peer-flush and memory latency. It holds a direct-mapped table of one peer cache's line states (I/S/M), so the requesting cache's MESI transitions get realistic HIT/HITM/NOHIT and C inputs. Sits between the cache MESI FSM outputs and the trace-driven testbench.

## Interface
- INDEX_BITS, 4, peer table index width; DEPTH = 2**INDEX_BITS entries
- MEM_LAT, 4, memory access cycles (>=1)
- FLUSH_CYCLES, 2, peer write-back cycles on HITM (>=1)
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- bus_req  in  1  initiator presents an operation
- bus_op  in  2  0=BusRd, 1=BusRdX, 2=BusUpgr, 3=Flush
- bus_addr  in  32  byte address; offset [5:0], index [6+INDEX_BITS-1:6], tag [31:6+INDEX_BITS]
- bus_ready  out  1  combinational, high only in IDLE
- bus_busy  out  1  registered, high in every non-IDLE state
- rsp_valid  out  1  one-cycle response strobe
- snoop_result  out  2  0=NOHIT, 1=HIT, 2=HITM; valid with rsp_valid
- c_shared  out  1  peer held the line (S or M) at snoop; valid with rsp_valid
- snp_wr  in  1  preload one peer table entry
- snp_addr  in  32  preload address (index/tag decoded as bus_addr)
- snp_state  in  2  0=I, 1=S, 2=M (3 treated as I)
- hit_cntr  out  16  count of HIT responses, wraps
- hitm_cntr  out  16  count of HITM responses, wraps
- proto_err  out  1  sticky protocol error flag

## Operation
- FSM states: IDLE, SNOOP, PFLUSH, MEM, RESP.
- Transfer when bus_req & bus_ready; bus_op/bus_addr registered; next state SNOOP.
- SNOOP (1 cycle): lookup entry[index]; match = valid state != I and stored tag == tag. Result: match S -> HIT, c_shared=1; match M -> HITM, c_shared=1; else NOHIT, c_shared=0. Flush op: lookup skipped, result NOHIT, c_shared=0.
- Table update on SNOOP exit: BusRd hit M -> S; BusRdX or BusUpgr hit (S or M) -> I; all else unchanged.
- After SNOOP: HITM -> PFLUSH (FLUSH_CYCLES cycles) -> RESP; BusUpgr non-HITM -> RESP; otherwise -> MEM (MEM_LAT cycles) -> RESP.
- RESP: rsp_valid=1 one cycle, counters update, -> IDLE.
- snoop_result/c_shared registered at SNOOP exit, held until next SNOOP exit.
- snp_wr honoured only while bus_ready, else ignored; writes tag and state. snp_wr and accepted bus_req in same cycle: write lands first, SNOOP sees it.
- No queueing: bus_req while not ready is not captured; initiator holds bus_req until bus_ready.

## Timing
- Reset: state IDLE, all table entries I, rsp_valid 0, bus_busy 0, snoop_result 0, c_shared 0, counters 0, proto_err 0. rst mid-operation drops the op; no rsp_valid issued.
- Accept edge = cycle 0. rsp_valid high in cycle: MEM_LAT+2 (BusRd/BusRdX NOHIT/HIT, Flush); FLUSH_CYCLES+2 (HITM); 2 (BusUpgr non-HITM).
- bus_ready low from cycle 1 through RESP; high again in cycle after RESP, so back-to-back ops start one cycle after rsp_valid.
- Latency counter sized ceil(log2(max(MEM_LAT,FLUSH_CYCLES)+1)); no wrap within a phase.

## Configuration
- BUS_RSP_PROTO_CHK_EN defined: proto_err sets (sticky until rst) at SNOOP exit when BusUpgr matches an M entry (requester cannot legally hold S); response still HITM with PFLUSH path. Also sets if snp_state=3 is written.
- Not defined: proto_err tied 0; all other behaviour identical.

## Test plan
- Reset, BusRd addr 0x0000_1040, MEM_LAT=4 -> rsp_valid at cycle 6, NOHIT, c_shared=0, counters 0.
- Preload 0x0000_1040 as S, BusRd same addr -> cycle 6 HIT, c_shared=1, hit_cntr=1, entry stays S.
- Preload 0x0000_2080 as M, BusRdX same addr, FLUSH_CYCLES=2 -> cycle 4 HITM, hitm_cntr=1; repeat BusRd -> NOHIT (entry now I).
- Preload S at 0x0000_0040, BusRd 0x0001_0040 (same index, other tag) -> NOHIT; BusUpgr 0x0000_0040 -> cycle 2 HIT, entry I.
- With BUS_RSP_PROTO_CHK_EN, preload M at 0x0000_0100, BusUpgr -> HITM at cycle 4, proto_err=1 held until rst.
- Assert rst in MEM cycle 3 of a BusRd -> no rsp_valid, bus_ready=1 next cycle, preloaded entries cleared to I.
